alu_operand_stage: RTL and testbench

Execute-stage front end that sits directly upstream of the 32-bit ALU. It accepts one decoded instruction per cycle, decodes opcode/funct into the ALU's 4-bit control code, selects immediates, and resolves operand forwarding from the two downstream stages. It then holds `input_a`/`input_b`/`control` in a valid/ready output register that the ALU samples on its posedge.

---
 rtl/alu_operand_stage_if.sv | 42 ++++
 rtl/alu_operand_stage.sv | 146 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - instruction-in / operand-out bus of the ALU operand stage
interface alu_operand_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs_idx;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [15:0] imm16;
   logic        ex_fwd_valid;
   logic [4:0]  ex_fwd_reg;
   logic [31:0] ex_fwd_data;
   logic        ex_fwd_is_load;
   logic        wb_fwd_valid;
   logic [4:0]  wb_fwd_reg;
   logic [31:0] wb_fwd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic [3:0]  control;
   logic [4:0]  dest_reg;
   logic        dest_we;
   logic        illegal;

   modport master (
      output in_valid, opcode, funct, rs_idx, rt_idx, rd_idx, rs_data, rt_data, imm16,
      output ex_fwd_valid, ex_fwd_reg, ex_fwd_data, ex_fwd_is_load,
      output wb_fwd_valid, wb_fwd_reg, wb_fwd_data, out_ready,
      input  in_ready, out_valid, input_a, input_b, control, dest_reg, dest_we, illegal
   );

   modport slave (
      input  in_valid, opcode, funct, rs_idx, rt_idx, rd_idx, rs_data, rt_data, imm16,
      input  ex_fwd_valid, ex_fwd_reg, ex_fwd_data, ex_fwd_is_load,
      input  wb_fwd_valid, wb_fwd_reg, wb_fwd_data, out_ready,
      output in_ready, out_valid, input_a, input_b, control, dest_reg, dest_we, illegal
   );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode, immediate select and forwarding ahead of the ALU
module alu_operand_stage #(
   parameter bit FWD_EN = 1'b1
) (
   input logic           clock,
   input logic           reset_n,
   input logic           flush,
   alu_operand_stage_if.slave bus
);

   logic        out_valid_q;
   logic [31:0] input_a_q, input_a_d;
   logic [31:0] input_b_q, input_b_d;
   logic [3:0]  control_q, control_d;
   logic [4:0]  dest_reg_q, dest_reg_d;
   logic        dest_we_q, dest_we_d;
   logic        illegal_q, illegal_d;

   logic        reads_rt;
   logic        use_imm;
   logic        imm_zext;
   logic [31:0] imm_ext;
   logic        ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
   logic        load_hazard;
   logic        fill;

   // Opcode/funct decode into ALU control, destination and operand-source selects
   always_comb begin
      control_d  = 4'hF;
      illegal_d  = 1'b1;
      dest_we_d  = 1'b0;
      dest_reg_d = 5'd0;
      reads_rt   = 1'b0;
      use_imm    = 1'b0;
      imm_zext   = 1'b0;
      case (bus.opcode)
         6'h00: begin
            illegal_d = 1'b0;
            case (bus.funct)
               6'h20:   control_d = 4'h2;
               6'h21:   control_d = 4'h3;
               6'h22:   control_d = 4'h6;
               6'h23:   control_d = 4'h6;
               6'h24:   control_d = 4'h0;
               6'h25:   control_d = 4'h1;
               6'h27:   control_d = 4'hC;
               6'h2A:   control_d = 4'h7;
               default: illegal_d = 1'b1;
            endcase
            if (!illegal_d) begin
               dest_we_d  = 1'b1;
               dest_reg_d = bus.rd_idx;
               reads_rt   = 1'b1;
            end
         end
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23: begin
            illegal_d  = 1'b0;
            dest_we_d  = 1'b1;
            dest_reg_d = bus.rt_idx;
            use_imm    = 1'b1;
            case (bus.opcode)
               6'h09:   control_d = 4'h3;
               6'h0A:   control_d = 4'h7;
               6'h0C:   begin control_d = 4'h0; imm_zext = 1'b1; end
               6'h0D:   begin control_d = 4'h1; imm_zext = 1'b1; end
               default: control_d = 4'h2;
            endcase
         end
         6'h2B: begin
            illegal_d = 1'b0;
            control_d = 4'h2;
            use_imm   = 1'b1;
            reads_rt  = 1'b1;
         end
         6'h04: begin
            illegal_d = 1'b0;
            control_d = 4'h6;
            reads_rt  = 1'b1;
         end
         default: ;
      endcase
   end

   assign imm_ext = imm_zext ? {16'h0000, bus.imm16} : {{16{bus.imm16[15]}}, bus.imm16};

   // Register index 0 is hardwired, so it never matches a forwarding source
   assign ex_hit_a = FWD_EN && bus.ex_fwd_valid && (bus.ex_fwd_reg != 5'd0) && (bus.ex_fwd_reg == bus.rs_idx);
   assign wb_hit_a = FWD_EN && bus.wb_fwd_valid && (bus.wb_fwd_reg != 5'd0) && (bus.wb_fwd_reg == bus.rs_idx);
   assign ex_hit_b = FWD_EN && bus.ex_fwd_valid && (bus.ex_fwd_reg != 5'd0) && (bus.ex_fwd_reg == bus.rt_idx);
   assign wb_hit_b = FWD_EN && bus.wb_fwd_valid && (bus.wb_fwd_reg != 5'd0) && (bus.wb_fwd_reg == bus.rt_idx);

   // Operand muxes: EX beats WB beats register file; illegal instructions pass raw data
   always_comb begin
      input_a_d = bus.rs_data;
      input_b_d = bus.rt_data;
      if (!illegal_d) begin
         if (ex_hit_a)      input_a_d = bus.ex_fwd_data;
         else if (wb_hit_a) input_a_d = bus.wb_fwd_data;
      end
      if (use_imm)                   input_b_d = imm_ext;
      else if (reads_rt && ex_hit_b) input_b_d = bus.ex_fwd_data;
      else if (reads_rt && wb_hit_b) input_b_d = bus.wb_fwd_data;
   end

   // A load in EX has no data yet; stall any consumer of its destination
   assign load_hazard = bus.in_valid && bus.ex_fwd_valid && bus.ex_fwd_is_load
                        && (bus.ex_fwd_reg != 5'd0)
                        && ((bus.ex_fwd_reg == bus.rs_idx) || (reads_rt && (bus.ex_fwd_reg == bus.rt_idx)));

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && !load_hazard && !flush;
   assign fill         = bus.in_valid && bus.in_ready;

   // Output register: flush kills, fill replaces, consume-without-fill drains
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         input_a_q   <= 32'd0;
         input_b_q   <= 32'd0;
         control_q   <= 4'd0;
         dest_reg_q  <= 5'd0;
         dest_we_q   <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (fill) begin
         out_valid_q <= 1'b1;
         input_a_q   <= input_a_d;
         input_b_q   <= input_b_d;
         control_q   <= control_d;
         dest_reg_q  <= dest_reg_d;
         dest_we_q   <= dest_we_d;
         illegal_q   <= illegal_d;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.input_a   = input_a_q;
   assign bus.input_b   = input_b_q;
   assign bus.control   = control_q;
   assign bus.dest_reg  = dest_reg_q;
   assign bus.dest_we   = dest_we_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed-vector bench for alu_operand_stage
module tb_alu_operand_stage;
   logic clock;
   logic reset_n;
   logic flush;
   int   n_checks;
   int   n_errors;

   alu_operand_stage_if bus ();

   alu_operand_stage #(.FWD_EN(1'b1)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
      bus.opcode  = op;
      bus.funct   = fn;
      bus.rs_idx  = rs;
      bus.rt_idx  = rt;
      bus.rd_idx  = rd;
      bus.rs_data = rsd;
      bus.rt_data = rtd;
      bus.imm16   = imm;
   endtask

   task automatic no_fwd();
      bus.ex_fwd_valid   = 1'b0;
      bus.ex_fwd_reg     = 5'd0;
      bus.ex_fwd_data    = 32'd0;
      bus.ex_fwd_is_load = 1'b0;
      bus.wb_fwd_valid   = 1'b0;
      bus.wb_fwd_reg     = 5'd0;
      bus.wb_fwd_data    = 32'd0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      flush    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      no_fwd();
      drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
      #2;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_input_a", bus.input_a, 32'd0);
      check("rst_input_b", bus.input_b, 32'd0);
      check("rst_control", {28'd0, bus.control}, 32'd0);
      check("rst_dest", {27'd0, bus.dest_reg}, 32'd0);
      check("rst_we_ill", {30'd0, bus.dest_we, bus.illegal}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      reset_n = 1'b1;
      step();

      // ADD 5 + -3
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h0000_0005, 32'hFFFF_FFFD, 16'd0);
      bus.in_valid = 1'b1;
      step();
      check("add_valid", {31'd0, bus.out_valid}, 32'd1);
      check("add_ctrl", {28'd0, bus.control}, 32'h2);
      check("add_a", bus.input_a, 32'h5);
      check("add_b", bus.input_b, 32'hFFFF_FFFD);
      check("add_dest", {27'd0, bus.dest_reg}, 32'd3);
      check("add_we", {31'd0, bus.dest_we}, 32'd1);

      // ORI zero-extends, EX match on rt must not override the immediate
      drive(6'h0D, 6'h00, 5'd1, 5'd7, 5'd0, 32'h100, 32'h5555, 16'h8001);
      bus.ex_fwd_valid = 1'b1; bus.ex_fwd_reg = 5'd7; bus.ex_fwd_data = 32'hDEAD;
      step();
      no_fwd();
      check("ori_b", bus.input_b, 32'h0000_8001);
      check("ori_ctrl", {28'd0, bus.control}, 32'h1);
      check("ori_dest", {27'd0, bus.dest_reg}, 32'd7);

      // ADDI sign-extends
      drive(6'h08, 6'h00, 5'd1, 5'd6, 5'd0, 32'h100, 32'h5555, 16'h8001);
      step();
      check("addi_b", bus.input_b, 32'hFFFF_8001);
      check("addi_ctrl", {28'd0, bus.control}, 32'h2);

      // SUB with both EX and WB matching rs: EX wins
      drive(6'h00, 6'h22, 5'd4, 5'd5, 5'd9, 32'hAAAA, 32'h1, 16'd0);
      bus.ex_fwd_valid = 1'b1; bus.ex_fwd_reg = 5'd4; bus.ex_fwd_data = 32'h11;
      bus.wb_fwd_valid = 1'b1; bus.wb_fwd_reg = 5'd4; bus.wb_fwd_data = 32'h22;
      step();
      check("sub_ex_a", bus.input_a, 32'h11);
      check("sub_ctrl", {28'd0, bus.control}, 32'h6);

      // Same with rs_idx = 0 and sources on r0: never forwarded
      drive(6'h00, 6'h22, 5'd0, 5'd5, 5'd9, 32'hAAAA, 32'h1, 16'd0);
      bus.ex_fwd_reg = 5'd0; bus.wb_fwd_reg = 5'd0;
      step();
      check("sub_r0_a", bus.input_a, 32'hAAAA);

      // WB-only match on rt for an R-type
      drive(6'h00, 6'h25, 5'd1, 5'd9, 5'd2, 32'h1, 32'h2, 16'd0);
      bus.ex_fwd_valid = 1'b0;
      bus.wb_fwd_valid = 1'b1; bus.wb_fwd_reg = 5'd9; bus.wb_fwd_data = 32'h33;
      step();
      check("or_wb_b", bus.input_b, 32'h33);

      // BEQ reads rt through EX forwarding, no register write
      drive(6'h04, 6'h00, 5'd1, 5'd9, 5'd2, 32'h1, 32'h2, 16'h0004);
      bus.ex_fwd_valid = 1'b1; bus.ex_fwd_reg = 5'd9; bus.ex_fwd_data = 32'h44;
      step();
      no_fwd();
      check("beq_b", bus.input_b, 32'h44);
      check("beq_ctrl_we", {27'd0, bus.control, bus.dest_we}, {27'd0, 4'h6, 1'b0});

      // SW: sign-extended immediate, no write, dest 0
      drive(6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 32'h1000, 32'h2, 16'hFFFC);
      step();
      check("sw_b", bus.input_b, 32'hFFFF_FFFC);
      check("sw_dest_we", {26'd0, bus.dest_reg, bus.dest_we}, 32'd0);

      // Load-use hazard: LW in EX writes r8, AND reads r8 -> two stall cycles
      drive(6'h00, 6'h24, 5'd8, 5'd1, 5'd10, 32'h0, 32'h0F0F, 16'd0);
      bus.ex_fwd_valid = 1'b1; bus.ex_fwd_reg = 5'd8; bus.ex_fwd_is_load = 1'b1;
      #1;
      check("hz_ready0", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("hz_bubble0", {31'd0, bus.out_valid}, 32'd0);
      check("hz_ready1", {31'd0, bus.in_ready}, 32'd0);
      step();
      check("hz_bubble1", {31'd0, bus.out_valid}, 32'd0);
      no_fwd();
      bus.wb_fwd_valid = 1'b1; bus.wb_fwd_reg = 5'd8; bus.wb_fwd_data = 32'h88;
      #1;
      check("hz_ready_rel", {31'd0, bus.in_ready}, 32'd1);
      step();
      no_fwd();
      check("hz_and_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hz_and_a", bus.input_a, 32'h88);
      check("hz_and_ctrl", {28'd0, bus.control}, 32'h0);

      // Backpressure for three cycles with input continuously valid
      drive(6'h00, 6'h21, 5'd1, 5'd2, 5'd11, 32'h1, 32'h10, 16'd0);
      step();
      bus.out_ready = 1'b0;
      drive(6'h00, 6'h21, 5'd1, 5'd2, 5'd12, 32'h2, 32'h20, 16'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
         step();
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_a", bus.input_a, 32'h1);
         check("bp_dest", {27'd0, bus.dest_reg}, 32'd11);
      end
      bus.out_ready = 1'b1;
      step();
      check("bp_next_a", bus.input_a, 32'h2);
      check("bp_next_valid", {31'd0, bus.out_valid}, 32'd1);
      drive(6'h00, 6'h21, 5'd1, 5'd2, 5'd13, 32'h3, 32'h30, 16'd0);
      step();
      check("bp_third_a", bus.input_a, 32'h3);

      // Unsupported funct 0x18 passes raw operands and flags illegal
      drive(6'h00, 6'h18, 5'd4, 5'd5, 5'd6, 32'h10, 32'h20, 16'd0);
      bus.ex_fwd_valid = 1'b1; bus.ex_fwd_reg = 5'd4; bus.ex_fwd_data = 32'h99;
      step();
      no_fwd();
      check("ill_flag", {31'd0, bus.illegal}, 32'd1);
      check("ill_ctrl", {28'd0, bus.control}, 32'hF);
      check("ill_we", {31'd0, bus.dest_we}, 32'd0);
      check("ill_a", bus.input_a, 32'h10);
      check("ill_b", bus.input_b, 32'h20);

      // Flush while stalled kills the held entry and blocks the fill
      bus.out_ready = 1'b0;
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 16'd0);
      step();
      flush = 1'b1;
      #1;
      check("fl_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      flush = 1'b0;
      check("fl_valid", {31'd0, bus.out_valid}, 32'd0);

      // Reset mid-stall clears outputs without a clock edge
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("rs_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rs_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rs_a", bus.input_a, 32'd0);
      check("rs_b", bus.input_b, 32'd0);
      check("rs_ctrl_dest_we", {22'd0, bus.control, bus.dest_reg, bus.dest_we}, 32'd0);
      bus.in_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
